// File: rtl/fcl_uart_tx_arbiter.sv
// Round-robin arbiter that lends one UART transmitter to a client for a whole packet,
// sequencing bytes through the send/done handshake under a per-byte watchdog.
module fcl_uart_tx_arbiter #(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 8192
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic [NUM_CLIENTS-1:0]   client_req,
  input  logic [8*NUM_CLIENTS-1:0] client_data,
  input  logic [NUM_CLIENTS-1:0]   client_last,
  output logic [NUM_CLIENTS-1:0]   client_ack,
  output logic [NUM_CLIENTS-1:0]   grant,
  output logic                     timeout_err,
  output logic                     arb_busy,
  output logic [7:0]               uart_tx_data,
  output logic                     uart_tx_send,
  input  logic                     uart_tx_done
);

  localparam int unsigned PtrW = $clog2(NUM_CLIENTS);
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_CLIENTS - 1);
  localparam logic [WdW-1:0]  WdLimit = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWait,
    StGap
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [PtrW-1:0]        gidx_q, gidx_d;
  logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]             data_q, data_d;
  logic                   last_q, last_d;
  logic                   send_q, send_d;
  logic [WdW-1:0]         wdog_q, wdog_d;
  logic [GapW-1:0]        gap_q, gap_d;

  logic [PtrW-1:0]        pick_idx;
  logic                   pick_vld;
  logic [PtrW-1:0]        nxt_ptr;
  logic                   ack_en;
  logic                   to_hit;
  int unsigned            idx;

  // First requester at or after rr_ptr, ascending with wrap.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_CLIENTS) begin
        idx = idx - NUM_CLIENTS;
      end
      if (!pick_vld && client_req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = PtrW'(idx);
      end
    end
  end

  assign nxt_ptr = (gidx_q == LastIdx) ? '0 : gidx_q + PtrW'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    last_d   = last_q;
    send_d   = 1'b0;
    wdog_d   = wdog_q;
    gap_d    = gap_q;
    ack_en   = 1'b0;
    to_hit   = 1'b0;

    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          grant_d = NUM_CLIENTS'(1) << pick_idx;
          gidx_d  = pick_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!client_req[gidx_q]) begin
          grant_d = '0;
          state_d = StIdle;
        end else begin
          ack_en  = 1'b1;
          data_d  = client_data[{gidx_q, 3'b000} +: 8];
          last_d  = client_last[gidx_q];
          send_d  = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        // Done takes priority over a coincident watchdog expiry.
        if (uart_tx_done) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = nxt_ptr;
          end
          if (GAP_CYCLES > 0) begin
            gap_d   = '0;
            state_d = StGap;
          end else begin
            state_d = last_q ? StIdle : StLoad;
          end
        end else if (wdog_q == WdLimit) begin
          to_hit   = 1'b1;
          grant_d  = '0;
          rr_ptr_d = nxt_ptr;
          state_d  = StIdle;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + WdW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = (|grant_q) ? StLoad : StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      data_q   <= 8'h00;
      last_q   <= 1'b0;
      send_q   <= 1'b0;
      wdog_q   <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      last_q   <= last_d;
      send_q   <= send_d;
      wdog_q   <= wdog_d;
      gap_q    <= gap_d;
    end
  end

  // Ack and abort are same-cycle pulses; gating with reset keeps a reset cycle silent.
  assign client_ack   = (ack_en && !reset) ? grant_q : '0;
  assign timeout_err  = to_hit && !reset;
  assign grant        = grant_q;
  assign arb_busy     = (state_q != StIdle);
  assign uart_tx_data = data_q;
  assign uart_tx_send = send_q;

endmodule

// File: tb/tb_fcl_uart_tx_arbiter.sv
// Directed bench for fcl_uart_tx_arbiter: client and UART models drive two instances
// (no gap / short watchdog, and a 3-cycle gap) and logs are checked against hand timing.
module tb_fcl_uart_tx_arbiter;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [N-1:0]     client_req, client_last;
  logic [8*N-1:0]   client_data;
  logic             uart_tx_done;
  logic [N-1:0]     a_ack, a_grant, g_ack, g_grant;
  logic             a_to, a_busy, a_send, g_to, g_busy, g_send;
  logic [7:0]       a_data, g_data;

  fcl_uart_tx_arbiter #(.NUM_CLIENTS(N), .GAP_CYCLES(0), .TIMEOUT_CYCLES(16)) u_dut (
    .sys_clk(clk), .reset(reset), .client_req(client_req), .client_data(client_data),
    .client_last(client_last), .client_ack(a_ack), .grant(a_grant), .timeout_err(a_to),
    .arb_busy(a_busy), .uart_tx_data(a_data), .uart_tx_send(a_send),
    .uart_tx_done(uart_tx_done)
  );

  fcl_uart_tx_arbiter #(.NUM_CLIENTS(N), .GAP_CYCLES(3), .TIMEOUT_CYCLES(64)) u_gap (
    .sys_clk(clk), .reset(reset), .client_req(client_req), .client_data(client_data),
    .client_last(client_last), .client_ack(g_ack), .grant(g_grant), .timeout_err(g_to),
    .arb_busy(g_busy), .uart_tx_data(g_data), .uart_tx_send(g_send),
    .uart_tx_done(uart_tx_done)
  );

  logic         sel_gap;
  logic [N-1:0] m_ack, m_grant;
  logic         m_to, m_busy, m_send;
  logic [7:0]   m_data;
  assign m_ack   = sel_gap ? g_ack   : a_ack;
  assign m_grant = sel_gap ? g_grant : a_grant;
  assign m_to    = sel_gap ? g_to    : a_to;
  assign m_busy  = sel_gap ? g_busy  : a_busy;
  assign m_send  = sel_gap ? g_send  : a_send;
  assign m_data  = sel_gap ? g_data  : a_data;

  // Client and UART model state
  logic [7:0]   pkt [N][4];
  int unsigned  plen [N];
  int unsigned  pidx [N];
  logic [N-1:0] act;
  logic         rep_mode, uart_en;
  int unsigned  ucnt, frame;

  // Logs
  int unsigned  cyc, n_cmp, n_err;
  int unsigned  send_cnt, done_cnt, ack_tot, gnt_cnt, to_cnt, viol, busy_cycles;
  logic [7:0]   send_data [32];
  int unsigned  send_cyc [32], done_cyc [32], ack_cyc [32], gnt_cyc [32];
  logic [N-1:0] gnt_hist [32];
  int unsigned  ack_per [N];
  int unsigned  to_cyc, gclr_cyc, busy_fall_cyc;
  logic [N-1:0] prev_grant, s_grant, s_ack;
  logic         prev_send, prev_busy, s_to, s_busy, s_send;
  logic [7:0]   s_data;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_clients();
    for (int i = 0; i < N; i++) begin
      int unsigned ix;
      ix = (pidx[i] < plen[i]) ? pidx[i] : 0;
      client_req[i] = act[i] && (pidx[i] < plen[i]);
      client_data[8*i +: 8] = pkt[i][ix];
      client_last[i] = (ix + 1 == plen[i]);
    end
  endtask

  task automatic clear_logs();
    send_cnt = 0; done_cnt = 0; ack_tot = 0; gnt_cnt = 0; to_cnt = 0; viol = 0;
    busy_cycles = 0; to_cyc = 0; gclr_cyc = 0; busy_fall_cyc = 0;
    prev_grant = '0; prev_send = 1'b0; prev_busy = 1'b0;
    for (int i = 0; i < N; i++) ack_per[i] = 0;
  endtask

  task automatic load_pkt(input int c, input int unsigned len, input logic [31:0] bytes);
    for (int j = 0; j < 4; j++) pkt[c][j] = bytes[8*j +: 8];
    plen[c] = len;
    pidx[c] = 0;
    act[c]  = 1'b1;
    drive_clients();
  endtask

  // One clock cycle: sample mid-cycle, then update models just after the edge.
  task automatic step();
    logic [N-1:0] ack_now, grant_now;
    logic         to_now, send_now;
    @(negedge clk);
    s_grant = m_grant; s_ack = m_ack; s_to = m_to; s_busy = m_busy;
    s_send = m_send; s_data = m_data;
    if (m_send && send_cnt < 32) begin
      send_data[send_cnt] = m_data; send_cyc[send_cnt] = cyc; send_cnt++;
    end
    if (uart_tx_done && done_cnt < 32) begin
      done_cyc[done_cnt] = cyc; done_cnt++;
    end
    if (m_ack != '0) begin
      if (ack_tot < 32) ack_cyc[ack_tot] = cyc;
      ack_tot++;
      for (int i = 0; i < N; i++) if (m_ack[i]) ack_per[i]++;
    end
    if (m_to) begin
      to_cyc = cyc; to_cnt++;
    end
    if (m_grant != '0 && prev_grant == '0 && gnt_cnt < 32) begin
      gnt_hist[gnt_cnt] = m_grant; gnt_cyc[gnt_cnt] = cyc; gnt_cnt++;
    end
    if (m_grant == '0 && prev_grant != '0) gclr_cyc = cyc;
    if (!m_busy && prev_busy) busy_fall_cyc = cyc;
    if (m_busy) busy_cycles++;
    if (!$onehot0(m_ack) || !$onehot0(m_grant)) viol++;
    if (m_ack != '0 && m_ack != m_grant) viol++;
    if (m_send && prev_send) viol++;
    prev_grant = m_grant; prev_send = m_send; prev_busy = m_busy;
    ack_now = m_ack; grant_now = m_grant; to_now = m_to; send_now = m_send;

    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (ack_now[i]) begin
        pidx[i]++;
        if (rep_mode && pidx[i] >= plen[i]) pidx[i] = 0;
      end
      if (to_now && grant_now[i]) act[i] = 1'b0;
    end
    uart_tx_done = 1'b0;
    if (send_now) begin
      ucnt = frame;
    end else if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0 && uart_en) uart_tx_done = 1'b1;
    end
    drive_clients();
  endtask

  task automatic do_reset();
    reset = 1'b1; act = '0; rep_mode = 1'b0; uart_en = 1'b1; ucnt = 0; frame = 10;
    uart_tx_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      pidx[i] = 0; plen[i] = 0;
    end
    drive_clients();
    step(); step();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned b;
    b = 0;
    step();
    while (!(s_busy == 1'b0 && client_req == '0) && b < budget) begin
      step(); b++;
    end
    check_eq({tag, "_idle"}, 32'(b < budget), 1);
  endtask

  initial begin
    int unsigned n0, b, sc;
    n_cmp = 0; n_err = 0; cyc = 0; sel_gap = 1'b0;
    client_req = '0; client_last = '0; client_data = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 4; j++) pkt[i][j] = 8'h00;
    clear_logs();
    do_reset();

    // Reset state
    step();
    check_eq("rst_grant", 32'(s_grant), 0);
    check_eq("rst_ack", 32'(s_ack), 0);
    check_eq("rst_to", 32'(s_to), 0);
    check_eq("rst_busy", 32'(s_busy), 0);
    check_eq("rst_data", 32'(s_data), 0);
    check_eq("rst_send", 32'(s_send), 0);

    // Single client, 3-byte packet
    n0 = cyc;
    load_pkt(0, 3, 32'h0001FFFF);
    wait_idle("t1", 200);
    check_eq("t1_sends", send_cnt, 3);
    check_eq("t1_b0", 32'(send_data[0]), 32'hFF);
    check_eq("t1_b1", 32'(send_data[1]), 32'hFF);
    check_eq("t1_b2", 32'(send_data[2]), 32'h01);
    check_eq("t1_acks", ack_per[0], 3);
    check_eq("t1_grant_lat", gnt_cyc[0], n0 + 1);
    check_eq("t1_ack_lat", ack_cyc[0], n0 + 1);
    check_eq("t1_send_lat", send_cyc[0], n0 + 2);
    check_eq("t1_ack2_lat", ack_cyc[1], done_cyc[0] + 1);
    check_eq("t1_send2_lat", send_cyc[1], done_cyc[0] + 2);
    check_eq("t1_gclr", gclr_cyc, done_cyc[2] + 1);
    // rr_ptr now 1: client 1 wins over client 0
    clear_logs();
    load_pkt(0, 1, 32'h000000A0);
    load_pkt(1, 1, 32'h000000B0);
    wait_idle("t1rr", 200);
    check_eq("t1_rr_first", 32'(gnt_hist[0]), 32'b0010);
    check_eq("t1_rr_second", 32'(gnt_hist[1]), 32'b0001);
    check_eq("t1_inv", viol, 0);

    // Clients 0 and 2, 2-byte packets, no interleave
    do_reset();
    load_pkt(0, 2, 32'h0000A1A0);
    load_pkt(2, 2, 32'h0000C1C0);
    wait_idle("t2", 300);
    check_eq("t2_g0", 32'(gnt_hist[0]), 32'b0001);
    check_eq("t2_g1", 32'(gnt_hist[1]), 32'b0100);
    check_eq("t2_d0", 32'(send_data[0]), 32'hA0);
    check_eq("t2_d1", 32'(send_data[1]), 32'hA1);
    check_eq("t2_d2", 32'(send_data[2]), 32'hC0);
    check_eq("t2_d3", 32'(send_data[3]), 32'hC1);
    // rr_ptr now 3: among 0,1,3 client 3 wins
    clear_logs();
    load_pkt(0, 1, 32'h00000001);
    load_pkt(1, 1, 32'h00000002);
    load_pkt(3, 1, 32'h00000003);
    wait_idle("t2rr", 300);
    check_eq("t2_rr3", 32'(gnt_hist[0]), 32'b1000);
    check_eq("t2_inv", viol, 0);

    // All clients continuously requesting 1-byte packets
    do_reset();
    rep_mode = 1'b1;
    for (int i = 0; i < N; i++) load_pkt(i, 1, 32'h10 + 32'(i));
    b = 0;
    while (gnt_cnt < 9 && b < 400) begin
      step(); b++;
    end
    check_eq("t3_run", 32'(gnt_cnt >= 9), 1);
    rep_mode = 1'b0;
    wait_idle("t3", 400);
    for (int k = 0; k < 9; k++)
      check_eq($sformatf("t3_order%0d", k), 32'(gnt_hist[k]), 32'(1 << (k % 4)));
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("t3_data%0d", k), 32'(send_data[k]), 32'h10 + 32'(k));
    check_eq("t3_inv", viol, 0);

    // Watchdog abort with silent UART
    do_reset();
    uart_en = 1'b0;
    load_pkt(1, 2, 32'h00006655);
    load_pkt(2, 1, 32'h00000077);
    b = 0;
    while (to_cnt == 0 && b < 100) begin
      step(); b++;
    end
    check_eq("t4_fired", to_cnt, 1);
    uart_en = 1'b1;
    check_eq("t4_to_cyc", to_cyc, send_cyc[0] + 16);
    step();
    check_eq("t4_gclr", 32'(s_grant), 0);
    check_eq("t4_idle", 32'(s_busy), 0);
    wait_idle("t4", 200);
    check_eq("t4_next", 32'(gnt_hist[1]), 32'b0100);
    check_eq("t4_next_cyc", gnt_cyc[1], to_cyc + 2);
    check_eq("t4_next_data", 32'(send_data[1]), 32'h77);
    check_eq("t4_to_total", to_cnt, 1);
    check_eq("t4_ack1", ack_per[1], 1);

    // Done on the watchdog's final cycle wins
    do_reset();
    frame = 15;
    load_pkt(0, 1, 32'h0000003C);
    wait_idle("t4b", 200);
    check_eq("t4b_no_to", to_cnt, 0);
    check_eq("t4b_gclr", gclr_cyc, done_cyc[0] + 1);
    check_eq("t4b_busy_fall", busy_fall_cyc, done_cyc[0] + 1);
    frame = 10;

    // Inter-byte gap of 3 cycles
    sel_gap = 1'b1;
    do_reset();
    load_pkt(0, 2, 32'h0000A55A);
    wait_idle("t5", 200);
    check_eq("t5_acks", ack_tot, 2);
    check_eq("t5_load2", ack_cyc[1], done_cyc[0] + 4);
    check_eq("t5_send2", send_cyc[1], done_cyc[0] + 5);
    check_eq("t5_data2", 32'(send_data[1]), 32'hA5);
    check_eq("t5_gclr", gclr_cyc, done_cyc[1] + 1);
    check_eq("t5_busy_fall", busy_fall_cyc, done_cyc[1] + 4);
    check_eq("t5_inv", viol, 0);
    sel_gap = 1'b0;

    // Reset while waiting on byte 2
    do_reset();
    load_pkt(0, 3, 32'h00332211);
    b = 0;
    while (send_cnt < 2 && b < 100) begin
      step(); b++;
    end
    check_eq("t6_reach", send_cnt, 2);
    step(); step(); step();
    reset = 1'b1; act = '0; drive_clients();
    step();
    reset = 1'b0;
    step();
    check_eq("t6_grant", 32'(s_grant), 0);
    check_eq("t6_ack", 32'(s_ack), 0);
    check_eq("t6_busy", 32'(s_busy), 0);
    check_eq("t6_send", 32'(s_send), 0);
    check_eq("t6_data", 32'(s_data), 0);
    sc = send_cnt; busy_cycles = 0;
    repeat (15) step();
    check_eq("t6_late_busy", busy_cycles, 0);
    check_eq("t6_late_send", send_cnt, sc);
    clear_logs();
    load_pkt(2, 1, 32'h00000044);
    wait_idle("t6", 200);
    check_eq("t6_regrant", 32'(gnt_hist[0]), 32'b0100);
    check_eq("t6_redata", 32'(send_data[0]), 32'h44);
    check_eq("t6_reack", ack_per[2], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fcl_uart_tx_arbiter.md
# fcl_uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among NUM_CLIENTS packet sources (servo bus, debug, telemetry). Grants the transmitter for a whole packet, feeds bytes one at a time through the UART send/done handshake, and guards each byte with a watchdog. Sits between the client byte streams and the UART's tx_data / tx_data_send / tx_done ports.

## Interface
- NUM_CLIENTS, 4: number of requesters (2..8).
- GAP_CYCLES, 0: idle sys_clk cycles inserted after every byte (0 = none).
- TIMEOUT_CYCLES, 8192: max cycles from send strobe to uart_tx_done before abort (must exceed one UART frame).

- sys_clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- client_req  in  NUM_CLIENTS  per-client request; held high for the entire packet.
- client_data  in  8*NUM_CLIENTS  byte for client i in bits [8i+7:8i].
- client_last  in  NUM_CLIENTS  marks the presented byte as the packet's final byte.
- client_ack  out  NUM_CLIENTS  one-cycle pulse: presented byte/last consumed; client advances next cycle.
- grant  out  NUM_CLIENTS  one-hot owner of the transmitter, 0 when idle.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- arb_busy  out  1  high in every state except IDLE.
- uart_tx_data  out  8  byte to UART; stable throughout SEND and WAIT.
- uart_tx_send  out  1  send strobe, high exactly one cycle per byte.
- uart_tx_done  in  1  UART one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, SEND, WAIT, GAP.
- IDLE: if any client_req, pick the first requester at or after rr_ptr (ascending, wrapping); register its one-hot grant and go to LOAD. Otherwise stay.
- LOAD: if client_req[g] is low, clear grant and return to IDLE (no byte, no ack). Otherwise client_ack[g]=1 this cycle; on the clock edge, latch client_data[g] into uart_tx_data and client_last[g] into last_r; go to SEND.
- SEND: uart_tx_send=1; clear watchdog; go to WAIT.
- WAIT: uart_tx_send=0; watchdog increments each cycle.
  - On uart_tx_done: if last_r, clear grant and set rr_ptr=(g+1) mod NUM_CLIENTS; then go to GAP if GAP_CYCLES>0. Otherwise go to IDLE when last_r is set, or to LOAD when it is not.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without done: pulse timeout_err, clear grant, set rr_ptr=(g+1) mod NUM_CLIENTS, go to IDLE. The aborting client must drop req and restart its packet.
  - Done and timeout in the same cycle: done wins.
- GAP: count GAP_CYCLES cycles. Then go to LOAD if grant is still held, otherwise to IDLE.
- The grant never changes mid-packet. Requests from other clients wait.
- uart_tx_done outside WAIT is ignored.
- Width rules:
  - watchdog width = clogb2(TIMEOUT_CYCLES), saturating.
  - gap counter width = clogb2(GAP_CYCLES+1).
  - rr_ptr width = clogb2(NUM_CLIENTS-1), wraps at NUM_CLIENTS-1.

## Timing
- Reset values: grant=0, client_ack=0, timeout_err=0, arb_busy=0, uart_tx_data=8'h00, uart_tx_send=0, rr_ptr=0, state=IDLE.
- Reset mid-packet abandons the packet immediately with no ack or strobe. The UART is not reset by this block.
- Request seen in IDLE at cycle N:
  - grant and arb_busy high at N+1 (LOAD);
  - client_ack at N+1;
  - uart_tx_send at N+2, with uart_tx_data already valid;
  - WAIT from N+3.
- Done pulse at cycle M with GAP_CYCLES=0 and more bytes to send: LOAD at M+1, next send strobe at M+2. Per-byte overhead is 2 cycles plus the UART frame.
- The send strobe always returns low for at least one cycle between bytes, so the UART's rising-edge detector fires once per byte.
- At most one client_ack bit is high in any cycle.
- grant is always one-hot or zero.

## Test plan
- Single client, 3-byte packet {0xFF,0xFF,0x01}, last on 3rd, UART model with 10-cycle frame:
  - exactly 3 send strobes carrying 0xFF, 0xFF, 0x01;
  - 3 acks;
  - grant clears the cycle after the 3rd done;
  - rr_ptr=1.
- Clients 0 and 2 request simultaneously with 2-byte packets, rr_ptr=0:
  - client 0 transmits both bytes, then client 2 transmits both;
  - no interleaving;
  - final rr_ptr=3.
- All 4 clients request continuously with 1-byte packets: grant order 0,1,2,3,0,1,… and ordering stays fair across wrap.
- UART model never pulses done, TIMEOUT_CYCLES=16:
  - timeout_err pulses 15 cycles after WAIT entry;
  - grant clears and state returns to IDLE;
  - the next requester is granted.
- GAP_CYCLES=3, 2-byte packet: exactly 3 idle cycles between done and the next LOAD; ack count = 2.
- Reset during WAIT of byte 2:
  - all outputs return to reset values the next cycle;
  - a late uart_tx_done is ignored;
  - a new request is granted normally.
